// File: rtl/rggen_rtl_pkg.sv
// Shared types for the rggen bus responder.
//   rggen_status          : response status codes returned on the bus
//   rggen_responder_state : responder FSM states (also exported for debug)
package rggen_rtl_pkg;

  typedef enum logic [1:0] {
    RGGEN_OKAY         = 2'b00,
    RGGEN_EXOKAY       = 2'b01,
    RGGEN_SLAVE_ERROR  = 2'b10,
    RGGEN_DECODE_ERROR = 2'b11
  } rggen_status;

  typedef enum logic [1:0] {
    RESPONDER_IDLE = 2'b00,
    RESPONDER_BUSY = 2'b01,
    RESPONDER_RESP = 2'b10
  } rggen_responder_state;

endpackage

// File: rtl/rggen_bus_responder_storage.sv
// DEPTH x BUS_WIDTH word storage for the bus responder.
// Synchronous active-low reset clears every word; one byte-strobed write
// port (committed on the clock edge) and one combinational read port.
// Ports:
//   i_clk, i_rst_n            clock, synchronous active-low reset
//   write_enable              commit write_data into word write_index
//   write_index/write_data    target word and data
//   strobe                    per-byte write enables
//   read_index/read_data      combinational read
module rggen_bus_responder_storage #(
  parameter int BUS_WIDTH   = 32,
  parameter int DEPTH       = 16,
  parameter int INDEX_WIDTH = 4
) (
  input  logic                   i_clk,
  input  logic                   i_rst_n,
  input  logic                   write_enable,
  input  logic [INDEX_WIDTH-1:0] write_index,
  input  logic [BUS_WIDTH-1:0]   write_data,
  input  logic [BUS_WIDTH/8-1:0] strobe,
  input  logic [INDEX_WIDTH-1:0] read_index,
  output logic [BUS_WIDTH-1:0]   read_data
);

  logic [BUS_WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else if (write_enable) begin
      for (int b = 0; b < BUS_WIDTH / 8; b++) begin
        if (strobe[b]) begin
          mem[write_index][8*b+:8] <= write_data[8*b+:8];
        end
      end
    end
  end

  assign read_data = mem[read_index];

endmodule

// File: rtl/rggen_bus_responder_memory.sv
// Responder end of the rggen bus backed by a small word-addressed memory.
// Each request runs IDLE -> (BUSY for WAIT_CYCLES cycles) -> RESP -> IDLE.
// Optional feature macro: RGGEN_BUS_RESPONDER_LOCK_EN adds the i_lock port;
// a write captured while i_lock is high answers SLAVE_ERROR and is dropped.
//
// Handshake: the initiator raises bus_valid with stable request fields and
// holds them until bus_ready; bus_ready is a one-cycle pulse in RESP that
// carries bus_status/bus_read_data. Request fields are captured on the
// first IDLE cycle that sees bus_valid, so an early drop of bus_valid does
// not cancel the transaction.
//
// Ports:
//   i_clk, i_rst_n     clock, synchronous active-low reset
//   bus_valid .. bus_strobe       request from initiator
//   bus_ready, bus_status, bus_read_data  registered response
//   o_busy             high while a request is held (BUSY or RESP)
//   i_lock             write lock (lock build only)
//   debug_state        current FSM state
module rggen_bus_responder_memory
  import rggen_rtl_pkg::*;
#(
  parameter int ADDRESS_WIDTH = 8,
  parameter int BUS_WIDTH     = 32,
  parameter int DEPTH         = 16,
  parameter int WAIT_CYCLES   = 0
) (
  input  logic                     i_clk,
  input  logic                     i_rst_n,
  input  logic                     bus_valid,
  input  logic [ADDRESS_WIDTH-1:0] bus_address,
  input  logic                     bus_write,
  input  logic [BUS_WIDTH-1:0]     bus_write_data,
  input  logic [BUS_WIDTH/8-1:0]   bus_strobe,
  output logic                     bus_ready,
  output logic [1:0]               bus_status,
  output logic [BUS_WIDTH-1:0]     bus_read_data,
  output logic                     o_busy,
`ifdef RGGEN_BUS_RESPONDER_LOCK_EN
  input  logic                     i_lock,
`endif
  output logic [1:0]               debug_state
);

  localparam int ADDRESS_LSB    = $clog2(BUS_WIDTH) - 3;
  localparam int INDEX_WIDTH    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int COUNT_WIDTH    = $clog2(WAIT_CYCLES + 1);
  localparam int CW             = (COUNT_WIDTH > 0) ? COUNT_WIDTH : 1;
  localparam int WORD_ADDR_BITS = ADDRESS_WIDTH - ADDRESS_LSB;

  rggen_responder_state state;
  rggen_status          status;
  logic [CW-1:0]          counter;
  logic [INDEX_WIDTH-1:0] cap_index;
  logic                   cap_write;
  logic                   cap_error;
  logic [BUS_WIDTH-1:0]   cap_write_data;
  logic [BUS_WIDTH/8-1:0] cap_strobe;

  logic [WORD_ADDR_BITS-1:0] live_index;
  logic                      lock_hit;
  logic                      live_error;
  logic [INDEX_WIDTH-1:0]    rd_index;
  logic                      resp_error;
  logic                      resp_write;
  rggen_status               resp_status;
  logic [BUS_WIDTH-1:0]      resp_data;
  logic [BUS_WIDTH-1:0]      storage_read_data;
  logic                      write_enable;

  // Sub-word address bits carry no meaning for a word memory.
  wire unused_address_lsbs = ^bus_address[ADDRESS_LSB-1:0];

  assign live_index = bus_address[ADDRESS_WIDTH-1:ADDRESS_LSB];

`ifdef RGGEN_BUS_RESPONDER_LOCK_EN
  assign lock_hit = bus_write & i_lock;
`else
  assign lock_hit = 1'b0;
`endif

  assign live_error = (32'(live_index) >= 32'(DEPTH)) || lock_hit;

  // The response is computed on the cycle that enters RESP: from the live
  // request when coming straight from IDLE, else from the captured copy.
  always_comb begin
    rd_index    = cap_index;
    resp_error  = cap_error;
    resp_write  = cap_write;
    if (state == RESPONDER_IDLE) begin
      rd_index   = live_index[INDEX_WIDTH-1:0];
      resp_error = live_error;
      resp_write = bus_write;
    end
    resp_status = resp_error ? RGGEN_SLAVE_ERROR : RGGEN_OKAY;
    resp_data   = (resp_error || resp_write) ? '0 : storage_read_data;
  end

  // Writes land on the edge that ends RESP, so a reset during RESP wins.
  assign write_enable = (state == RESPONDER_RESP) && cap_write && !cap_error;

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      state          <= RESPONDER_IDLE;
      bus_ready      <= 1'b0;
      status         <= RGGEN_OKAY;
      bus_read_data  <= '0;
      o_busy         <= 1'b0;
      counter        <= '0;
      cap_index      <= '0;
      cap_write      <= 1'b0;
      cap_error      <= 1'b0;
      cap_write_data <= '0;
      cap_strobe     <= '0;
    end else begin
      case (state)
        RESPONDER_IDLE: begin
          if (bus_valid) begin
            cap_index      <= live_index[INDEX_WIDTH-1:0];
            cap_write      <= bus_write;
            cap_error      <= live_error;
            cap_write_data <= bus_write_data;
            cap_strobe     <= bus_strobe;
            o_busy         <= 1'b1;
            if (WAIT_CYCLES == 0) begin
              state         <= RESPONDER_RESP;
              bus_ready     <= 1'b1;
              status        <= resp_status;
              bus_read_data <= resp_data;
            end else begin
              counter <= CW'(WAIT_CYCLES - 1);
              state   <= RESPONDER_BUSY;
            end
          end
        end
        RESPONDER_BUSY: begin
          if (counter == '0) begin
            state         <= RESPONDER_RESP;
            bus_ready     <= 1'b1;
            status        <= resp_status;
            bus_read_data <= resp_data;
          end else begin
            counter <= counter - 1'b1;
          end
        end
        RESPONDER_RESP: begin
          state     <= RESPONDER_IDLE;
          bus_ready <= 1'b0;
          o_busy    <= 1'b0;
        end
        default: begin
          state     <= RESPONDER_IDLE;
          bus_ready <= 1'b0;
          o_busy    <= 1'b0;
        end
      endcase
    end
  end

  assign bus_status  = status;
  assign debug_state = state;

  rggen_bus_responder_storage #(
    .BUS_WIDTH   (BUS_WIDTH),
    .DEPTH       (DEPTH),
    .INDEX_WIDTH (INDEX_WIDTH)
  ) u_storage (
    .i_clk        (i_clk),
    .i_rst_n      (i_rst_n),
    .write_enable (write_enable),
    .write_index  (cap_index),
    .write_data   (cap_write_data),
    .strobe       (cap_strobe),
    .read_index   (rd_index),
    .read_data    (storage_read_data)
  );

endmodule
